// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared 32-bit ALU
//
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority, requester 0
// wins ties). Default build is round-robin.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   req_valid[1:0]           per-requester request valid
//   req_ready[1:0]           per-requester accept (one-hot grant in IDLE)
//   req_op   {r1, r0}        opcodes, OP_W bits each
//   req_in1  {r1, r0}        first operands, DATA_W bits each
//   req_in2  {r1, r0}        second operands, DATA_W bits each
//   rsp_valid[1:0]           result valid, bit = owning requester
//   rsp_ready[1:0]           result accept, only the owner bit is honoured
//   rsp_out                  shared result bus
//   rsp_equal                in1 == in2 for the executed op
//   rsp_err                  opcode was not a defined ALU code
//   busy                     FSM is not in IDLE

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_in1,
  input  logic [2*DATA_W-1:0] req_in2,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_out,
  output logic                rsp_equal,
  output logic                rsp_err,
  output logic                busy
);

  localparam logic [OP_W-1:0] ALU_SLL  = OP_W'(0);
  localparam logic [OP_W-1:0] ALU_SRA  = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_SRL  = OP_W'(2);
  localparam logic [OP_W-1:0] ALU_ADD  = OP_W'(3);
  localparam logic [OP_W-1:0] ALU_SUB  = OP_W'(4);
  localparam logic [OP_W-1:0] ALU_AND  = OP_W'(5);
  localparam logic [OP_W-1:0] ALU_OR   = OP_W'(6);
  localparam logic [OP_W-1:0] ALU_XOR  = OP_W'(7);
  localparam logic [OP_W-1:0] ALU_NOR  = OP_W'(8);
  localparam logic [OP_W-1:0] ALU_CMP  = OP_W'(9);
  localparam logic [OP_W-1:0] ALU_CMPU = OP_W'(10);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   in1_q;
  logic [DATA_W-1:0]   in2_q;
  logic                owner_q;
  logic                last_grant_q;

  logic [1:0]          grant;
  logic                gnt_idx;
  logic [DATA_W-1:0]   alu_out;
  logic                alu_equal;
  logic                alu_bad;

  // Grant is computed every cycle but only exposed as req_ready in IDLE.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   grant = 2'b01;
`else
      // Tie goes to whoever was not served last.
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
`endif
      default: grant = 2'b00;
    endcase
  end

  assign gnt_idx   = grant[1];
  // Gated by rst_n so no handshake can be seen while reset is held.
  assign req_ready = (rst_n && state == IDLE) ? grant : 2'b00;

  // Shared ALU, driven only from the latched operands.
  always_comb begin
    alu_out   = '0;
    alu_bad   = 1'b0;
    alu_equal = (in1_q == in2_q);
    case (op_q)
      ALU_SLL:  alu_out = in1_q << in2_q[4:0];
      ALU_SRA:  alu_out = $signed(in1_q) >>> in2_q[4:0];
      ALU_SRL:  alu_out = in1_q >> in2_q[4:0];
      ALU_ADD:  alu_out = in1_q + in2_q;
      ALU_SUB:  alu_out = in1_q - in2_q;
      ALU_AND:  alu_out = in1_q & in2_q;
      ALU_OR:   alu_out = in1_q | in2_q;
      ALU_XOR:  alu_out = in1_q ^ in2_q;
      ALU_NOR:  alu_out = ~(in1_q | in2_q);
      ALU_CMP:  alu_out = {{(DATA_W-1){1'b0}}, ($signed(in1_q) < $signed(in2_q))};
      ALU_CMPU: alu_out = {{(DATA_W-1){1'b0}}, (in1_q < in2_q)};
      default:  alu_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= '0;
      in1_q        <= '0;
      in2_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid    <= 2'b00;
      rsp_out      <= '0;
      rsp_equal    <= 1'b0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Any non-zero grant here is a handshake because req_ready == grant.
          if (|grant) begin
            op_q         <= gnt_idx ? req_op[2*OP_W-1:OP_W]      : req_op[OP_W-1:0];
            in1_q        <= gnt_idx ? req_in1[2*DATA_W-1:DATA_W] : req_in1[DATA_W-1:0];
            in2_q        <= gnt_idx ? req_in2[2*DATA_W-1:DATA_W] : req_in2[DATA_W-1:0];
            owner_q      <= gnt_idx;
            last_grant_q <= gnt_idx;
            busy         <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          rsp_out   <= alu_out;
          rsp_equal <= alu_equal;
          rsp_err   <= alu_bad;
          rsp_valid <= owner_q ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner_q]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter

module tb_alu_arbiter;

  localparam logic [3:0] OP_SLL  = 4'd0;
  localparam logic [3:0] OP_SRA  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_CMP  = 4'd9;
  localparam logic [3:0] OP_CMPU = 4'd10;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_op;
  logic [63:0] req_in1;
  logic [63:0] req_in2;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_out;
  logic        rsp_equal;
  logic        rsp_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  alu_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_out   (rsp_out),
    .rsp_equal (rsp_equal),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[idx*4 +: 4]   = op;
    req_in1[idx*32 +: 32] = a;
    req_in2[idx*32 +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Polls on negedges until a response shows up; n = negedges waited.
  task automatic wait_rsp(output logic [1:0] v, output int n, output bit timeout);
    v = 2'b00;
    n = 0;
    timeout = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n++;
      if (rsp_valid !== 2'b00) begin
        v = rsp_valid;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    tests++; if (rsp_out !== 32'h0) begin fails++; $display("FAIL reset_rsp_out got %h exp 0", rsp_out); end
    tests++; if ({rsp_equal, rsp_err, busy} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {rsp_equal, rsp_err, busy}); end
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_add();
    set_req(0, OP_ADD, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL add_grant got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    tests++; if ({busy, rsp_valid, req_ready} !== 5'b1_00_00) begin fails++; $display("FAIL add_exec got %b exp 10000", {busy, rsp_valid, req_ready}); end
    @(negedge clk);
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL add_latency got %b exp 01", rsp_valid); end
    tests++; if (rsp_out !== 32'd12) begin fails++; $display("FAIL add_out got %h exp %h", rsp_out, 32'd12); end
    tests++; if ({rsp_equal, rsp_err} !== 2'b00) begin fails++; $display("FAIL add_flags got %b exp 00", {rsp_equal, rsp_err}); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    tests++; if ({busy, rsp_valid} !== 3'b000) begin fails++; $display("FAIL add_done got %b exp 000", {busy, rsp_valid}); end
  endtask

  task automatic test_tie_after_reset();
    logic [1:0] v; int n; bit to;
    do_reset();
    set_req(0, OP_SUB, 32'd3, 32'd3);
    set_req(1, OP_CMP, 32'hFFFF_FFFF, 32'd0);
    req_valid = 2'b11;
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL tie_grant0 got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b10;
    wait_rsp(v, n, to);
    tests++; if (to || v !== 2'b01) begin fails++; $display("FAIL tie_first got %b timeout %0d exp 01", v, to); end
    tests++; if ({rsp_out, rsp_equal} !== {32'h0, 1'b1}) begin fails++; $display("FAIL tie_sub got %h eq %b exp 0 eq 1", rsp_out, rsp_equal); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL tie_grant1 got %b exp 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(v, n, to);
    tests++; if (to || v !== 2'b10) begin fails++; $display("FAIL tie_second got %b timeout %0d exp 10", v, to); end
    tests++; if ({rsp_out, rsp_equal} !== {32'd1, 1'b0}) begin fails++; $display("FAIL tie_cmp got %h eq %b exp 1 eq 0", rsp_out, rsp_equal); end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_ops();
    logic [3:0]  ops [10] = '{OP_SLL, OP_SRA, OP_SRL, OP_SUB, OP_ADD, OP_AND, OP_OR, OP_NOR, OP_CMPU, OP_CMP};
    logic [31:0] as  [10] = '{32'd1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h0000_F0F0, 32'h0000_F0F0, 32'd0, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] bs  [10] = '{32'h24, 32'd4, 32'd4, 32'd1, 32'd2, 32'h0000_FF00, 32'h0000_0F0F, 32'd0, 32'd0, 32'd5};
    logic [31:0] exp [10] = '{32'h10, 32'hF800_0000, 32'h0800_0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_F000, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic        eqs [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0] v; int n; bit to;
    for (int k = 0; k < 10; k++) begin
      set_req(0, ops[k], as[k], bs[k]);
      req_valid = 2'b01;
      @(negedge clk);
      req_valid = 2'b00;
      // Inputs after the handshake must not reach the op in flight.
      set_req(0, 4'hF, $urandom, $urandom);
      wait_rsp(v, n, to);
      tests++;
      if (to || v !== 2'b01 || rsp_out !== exp[k] || rsp_equal !== eqs[k] || rsp_err !== 1'b0) begin
        fails++;
        $display("FAIL op%0d got v=%b out=%h eq=%b err=%b exp v=01 out=%h eq=%b err=0", k, v, rsp_out, rsp_equal, rsp_err, exp[k], eqs[k]);
      end
      rsp_ready = 2'b01;
      @(negedge clk);
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_invalid_op();
    logic [1:0] v; int n; bit to;
    set_req(1, 4'hF, 32'd9, 32'd9);
    req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(v, n, to);
    tests++; if (to || v !== 2'b10) begin fails++; $display("FAIL inv_valid got %b exp 10", v); end
    tests++; if ({rsp_out, rsp_err, rsp_equal} !== {32'h0, 1'b1, 1'b1}) begin fails++; $display("FAIL inv_result got %h err %b eq %b exp 0 err 1 eq 1", rsp_out, rsp_err, rsp_equal); end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_backpressure();
    logic [1:0] v; int n; bit to;
    set_req(0, OP_XOR, 32'hA5A5_0000, 32'h0000_FFFF);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(v, n, to);
    tests++; if (to || v !== 2'b01) begin fails++; $display("FAIL bp_valid got %b exp 01", v); end
    // New request and a non-owner ready bit must both be ignored while held.
    set_req(1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 2'b01 || rsp_out !== 32'hA5A5_FFFF || rsp_equal !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold%0d got v=%b out=%h eq=%b err=%b rdy=%b busy=%b exp v=01 out=a5a5ffff eq=0 err=0 rdy=00 busy=1", c, rsp_valid, rsp_out, rsp_equal, rsp_err, req_ready, busy);
      end
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL bp_reaccept got %b exp 10", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(v, n, to);
    tests++; if (to || v !== 2'b10 || rsp_out !== 32'h8000_0000) begin fails++; $display("FAIL bp_wrap got v=%b out=%h exp v=10 out=80000000", v, rsp_out); end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_in_exec();
    logic [1:0] v; int n; bit to;
    set_req(0, OP_ADD, 32'd1, 32'd2);
    req_valid = 2'b01;
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    tests++; if ({rsp_valid, busy, req_ready} !== 5'b00_0_00 || rsp_out !== 32'h0) begin fails++; $display("FAIL rexec_state got v=%b busy=%b rdy=%b out=%h exp 00 0 00 0", rsp_valid, busy, req_ready, rsp_out); end
    rst_n = 1'b1;
    set_req(0, OP_ADD, 32'd10, 32'd20);
    set_req(1, OP_ADD, 32'd40, 32'd50);
    #1;
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL rexec_tie got %b exp 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(v, n, to);
    tests++; if (to || v !== 2'b01 || rsp_out !== 32'd30) begin fails++; $display("FAIL rexec_next got v=%b out=%h exp v=01 out=1e", v, rsp_out); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_contention();
    logic [1:0] v; int n; bit to;
    logic [1:0] want;
    do_reset();
    set_req(0, OP_ADD, 32'd1, 32'd1);
    set_req(1, OP_ADD, 32'd2, 32'd2);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      want = 2'b01;
`else
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      wait_rsp(v, n, to);
      tests++;
      if (to || v !== want || n !== 2 || rsp_out !== ((want == 2'b01) ? 32'd2 : 32'd4)) begin
        fails++;
        $display("FAIL cont%0d got v=%b wait=%0d out=%h exp v=%b wait=2", k, v, n, rsp_out, want);
      end
      rsp_ready = v;
      @(negedge clk);
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op    = '0;
    req_in1   = '0;
    req_in2   = '0;
    test_reset();
    test_single_add();
    test_tie_after_reset();
    test_ops();
    test_invalid_op();
    test_backpressure();
    test_reset_in_exec();
    test_contention();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single 32-bit `alu` instance between two requesters, such as the EX stage and a multi-cycle address/branch helper. Arbitration is round-robin by default. Each accepted operation is latched, executed on the shared ALU, and returned through a registered response with a valid/ready handshake. It sits beside the execute stage, so the ALU does not have to be duplicated.

## Interface
- `DATA_W`, 32, operand/result width; only 32 is supported (ALU limit).
- `OP_W`, 4, ALU opcode width (`ALU_*` codes from `definitions.vh`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_valid` in 2: per-requester request valid; bit i = requester i.
- `req_ready` out 2: per-requester accept; a handshake occurs when `req_valid[i] & req_ready[i]`.
- `req_op` in 2*OP_W: opcodes, {req1, req0}.
- `req_in1` in 2*DATA_W: first operands, {req1, req0}.
- `req_in2` in 2*DATA_W: second operands, {req1, req0}.
- `rsp_valid` out 2: per-requester result valid.
- `rsp_ready` in 2: per-requester result accept.
- `rsp_out` out DATA_W: result; shared bus, owned by the requester whose `rsp_valid` bit is set.
- `rsp_equal` out 1: ALU `equal` flag for the result.
- `rsp_err` out 1: the opcode was not a defined `ALU_*` code.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready` = one-hot grant (combinational from `req_valid` and `last_grant`).
  - On a handshake: latch op, in1, in2 and owner; update `last_grant` to owner; go to EXEC.
  - No valid request: stay in IDLE.
- **EXEC**
  - Drive the ALU from the latched registers.
  - Register `out` into `rsp_out` and `equal` into `rsp_equal`; go to RESP.
- **RESP**
  - `rsp_valid[owner]` = 1.
  - On `rsp_ready[owner]`: go to IDLE.
  - Otherwise hold; `rsp_out`, `rsp_equal` and `rsp_err` stay stable.
- **Grant rule (round-robin)**
  - One requester valid: it wins.
  - Both valid: the requester != `last_grant` wins.
  - `last_grant` resets to 1, so requester 0 wins the first tie after reset.
- **Invalid opcode** (not one of SLL, SRA, SRL, ADD, SUB, AND, OR, XOR, NOR, CMP, CMPU):
  - The request is still accepted.
  - `rsp_out` = 32'h0 (never z); `rsp_equal` is computed normally; `rsp_err` = 1.
- `rsp_err` = 0 for valid opcodes.
- `req_ready` = 0 in EXEC and RESP; there is no request queuing.
- `rsp_ready` is ignored on any non-owner bit and in any state other than RESP.
- Requester inputs are sampled only at the handshake. Later changes do not affect the op in flight.

## Timing
- Reset values: state IDLE, `req_ready` 2'b00 while `rst_n`=0, `rsp_valid` 2'b00, `rsp_out` 32'h0, `rsp_equal` 0, `rsp_err` 0, `busy` 0, `last_grant` 1.
- Latency: handshake in cycle N -> `rsp_valid` high in cycle N+2.
- Throughput: at best one op every 3 cycles.
- Response handshake in cycle M -> `req_ready` can be asserted again in cycle M+1.
- Reset asserted mid-operation (EXEC or RESP):
  - The next cycle is IDLE with all outputs at their reset values.
  - The in-flight result is discarded and never presented.
- Simultaneous new request and pending response: the request waits; it is not accepted until IDLE.
- Shifts use `in2[4:0]` only; ADD and SUB wrap modulo 2^32 with no overflow flag.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, requester 0 always wins ties; `last_grant` is unused and requester 1 may starve.
  - Undefined (default): round-robin as specified above.

## Test plan
- **Single ADD:** after reset, req0 ADD in1=5, in2=7, handshake in cycle N -> `rsp_valid`=2'b01 in cycle N+2, `rsp_out`=12, `rsp_equal`=0, `rsp_err`=0.
- **Tie after reset:** both requesters valid; req0 SUB 3,3 and req1 CMP -1,0.
  - req0 is served first: `rsp_out`=0, `rsp_equal`=1.
  - req1 is served next: `rsp_out`=1.
- **Response backpressure:** `rsp_ready`=0 for 4 cycles in RESP -> `rsp_out`, `rsp_equal` and `rsp_err` are stable, `req_ready`=2'b00 and `busy`=1 throughout.
- **Invalid opcode:** req1 op=4'hF, in1=in2=9 -> `rsp_out`=32'h0, `rsp_err`=1, `rsp_equal`=1.
- **Reset in EXEC:** `rst_n`=0 during EXEC -> next cycle `rsp_valid`=0, `busy`=0; the following tie is granted to req0.
- **Continuous contention:** both requesters valid continuously for 6 ops -> grant order 0,1,0,1,0,1; with `ALU_ARB_FIXED_PRIO_EN` defined, the order is 0,0,0,0,0,0.
